// File: rtl/multi_start_stop_timer.sv
// ---------------------------------------------------------------------------
// multi_start_stop_timer
//
// Multi-channel edge-triggered window timer. A selected edge on a channel's
// sig input opens an 'active' window lasting (length+1)*(scale+1) clk cycles.
// Each channel has its own edge select, retrigger enable and level-gate abort.
// Every channel runs its own prescaler and tick counter, so the channels are
// fully independent.
//
// Ports
//   clk         in   system clock
//   aclr_n      in   asynchronous reset, active low
//   sclr        in   synchronous clear of FSMs, counters, shadows and outputs
//   sig         in   [CHANNELS]          asynchronous trigger inputs
//   scale       in   [PRE_WIDTH]         shared prescale, 1 tick = scale+1 clk
//   length      in   [CHANNELS*WIDTH]    per-channel length, ch i at [i*WIDTH +: WIDTH]
//   edge_sel    in   [CHANNELS*2]        per channel: 00 off, 01 rise, 10 fall, 11 both
//   retrig      in   [CHANNELS]          selected edge during a window restarts it
//   level_gate  in   [CHANNELS]          abort if sig returns to its pre-edge level
//   active      out  [CHANNELS]          window open (registered)
//   done        out  [CHANNELS]          1-clk pulse, window completed normally
//   abort       out  [CHANNELS]          1-clk pulse, window terminated early
//   any_active  out                      OR of active, one register stage later
// ---------------------------------------------------------------------------
module multi_start_stop_timer #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int PRE_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         aclr_n,
    input  logic                         sclr,
    input  logic [CHANNELS-1:0]          sig,
    input  logic [PRE_WIDTH-1:0]         scale,
    input  logic [CHANNELS*WIDTH-1:0]    length,
    input  logic [CHANNELS*2-1:0]        edge_sel,
    input  logic [CHANNELS-1:0]          retrig,
    input  logic [CHANNELS-1:0]          level_gate,
    output logic [CHANNELS-1:0]          active,
    output logic [CHANNELS-1:0]          done,
    output logic [CHANNELS-1:0]          abort,
    output logic                         any_active
);

    // State table (per channel)
    //   state    | meaning
    //   ST_IDLE  | window closed, waiting for a selected edge
    //   ST_RUN   | window open, prescaler and tick counter advancing
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [1:0] SEL_OFF  = 2'b00;
    localparam logic [1:0] SEL_RISE = 2'b01;
    localparam logic [1:0] SEL_FALL = 2'b10;
    localparam logic [1:0] SEL_BOTH = 2'b11;

    // ------------------------------------------------------------------
    // Input synchroniser and edge register. These keep tracking through
    // sclr so that a level held across a clear produces no spurious edge.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s_d_q;
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            s_d_q <= '0;
        end else begin
            sync_q[0] <= sig;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            s_d_q <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    // ------------------------------------------------------------------
    // Per-channel window FSM
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic                 state_q,    state_d;
        logic [PRE_WIDTH-1:0] timer_q,    timer_d;
        logic [PRE_WIDTH-1:0] scale_sh_q, scale_sh_d;
        logic [WIDTH-1:0]     cnt_q,      cnt_d;
        logic [WIDTH-1:0]     len_sh_q,   len_sh_d;
        logic                 done_q,     done_d;
        logic                 abort_q,    abort_d;

        logic [1:0]           sel;
        logic [WIDTH-1:0]     len_in;
        logic                 ev;
        logic                 tick;
        logic                 last_tick;
        logic                 gate_hit;

        assign sel    = edge_sel[2*i +: 2];
        assign len_in = length[i*WIDTH +: WIDTH];

        assign ev = ((sel == SEL_RISE) && rise[i]) ||
                    ((sel == SEL_FALL) && fall[i]) ||
                    ((sel == SEL_BOTH) && (rise[i] || fall[i]));

        assign tick      = (timer_q == scale_sh_q);
        assign last_tick = tick && (cnt_q == len_sh_q);

        // Gate only applies to single-edge modes: the pre-edge level is
        // low for rise and high for fall, so seeing it again means the
        // input dropped back before the window finished.
        assign gate_hit = level_gate[i] &&
                          (((sel == SEL_RISE) && !s[i]) ||
                           ((sel == SEL_FALL) &&  s[i]));

        always_comb begin
            state_d    = state_q;
            timer_d    = timer_q;
            cnt_d      = cnt_q;
            scale_sh_d = scale_sh_q;
            len_sh_d   = len_sh_q;
            done_d     = 1'b0;
            abort_d    = 1'b0;

            if (sclr) begin
                state_d    = ST_IDLE;
                timer_d    = '0;
                cnt_d      = '0;
                scale_sh_d = '0;
                len_sh_d   = '0;
            end else if (state_q == ST_IDLE) begin
                if (ev) begin
                    state_d    = ST_RUN;
                    timer_d    = '0;
                    cnt_d      = '0;
                    scale_sh_d = scale;
                    len_sh_d   = len_in;
                end
            end else if (sel == SEL_OFF) begin
                state_d = ST_IDLE;
                abort_d = 1'b1;
            end else if (gate_hit) begin
                state_d = ST_IDLE;
                abort_d = 1'b1;
            end else if (ev && retrig[i]) begin
                timer_d    = '0;
                cnt_d      = '0;
                scale_sh_d = scale;
                len_sh_d   = len_in;
            end else if (tick) begin
                timer_d = '0;
                if (last_tick) begin
                    // Counter is left at len_sh_q so it never passes the shadow.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge aclr_n) begin
            if (!aclr_n) begin
                state_q    <= ST_IDLE;
                timer_q    <= '0;
                cnt_q      <= '0;
                scale_sh_q <= '0;
                len_sh_q   <= '0;
                done_q     <= 1'b0;
                abort_q    <= 1'b0;
            end else begin
                state_q    <= state_d;
                timer_q    <= timer_d;
                cnt_q      <= cnt_d;
                scale_sh_q <= scale_sh_d;
                len_sh_q   <= len_sh_d;
                done_q     <= done_d;
                abort_q    <= abort_d;
            end
        end

        assign active[i] = (state_q == ST_RUN);
        assign done[i]   = done_q;
        assign abort[i]  = abort_q;
    end

    // ------------------------------------------------------------------
    // Summary flag, registered one stage behind active
    // ------------------------------------------------------------------
    logic any_active_q;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            any_active_q <= 1'b0;
        end else if (sclr) begin
            any_active_q <= 1'b0;
        end else begin
            any_active_q <= |active;
        end
    end

    assign any_active = any_active_q;

endmodule

// File: tb/tb_multi_start_stop_timer.sv
module tb_multi_start_stop_timer;

    localparam int CH   = 4;
    localparam int W    = 16;
    localparam int PW   = 16;
    localparam int SYNC = 2;

    logic               clk;
    logic               aclr_n;
    logic               sclr;
    logic [CH-1:0]      sig;
    logic [PW-1:0]      scale;
    logic [CH*W-1:0]    length;
    logic [CH*2-1:0]    edge_sel;
    logic [CH-1:0]      retrig;
    logic [CH-1:0]      level_gate;
    logic [CH-1:0]      active;
    logic [CH-1:0]      done;
    logic [CH-1:0]      abort;
    logic               any_active;

    multi_start_stop_timer #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .PRE_WIDTH   (PW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .aclr_n     (aclr_n),
        .sclr       (sclr),
        .sig        (sig),
        .scale      (scale),
        .length     (length),
        .edge_sel   (edge_sel),
        .retrig     (retrig),
        .level_gate (level_gate),
        .active     (active),
        .done       (done),
        .abort      (abort),
        .any_active (any_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each channel keeps the number of clk cycles left in
    // its window; a window opens with (length+1)*(scale+1) cycles.
    // ------------------------------------------------------------------
    longint        m_rem [CH];
    logic [CH-1:0] m_act, m_done, m_abort;
    logic          m_any;
    logic [CH-1:0] m_pipe [SYNC];
    logic [CH-1:0] m_sd;

    always @(posedge clk or negedge aclr_n) begin : model
        logic [CH-1:0] s, n_act, n_done, n_abort;
        longint        n_rem [CH];
        logic [1:0]    sel;
        logic          ev, gate;
        longint        wlen;
        if (!aclr_n) begin
            for (int c = 0; c < CH; c++) m_rem[c] <= 0;
            m_act   <= '0;
            m_done  <= '0;
            m_abort <= '0;
            m_any   <= 1'b0;
            for (int k = 0; k < SYNC; k++) m_pipe[k] <= '0;
            m_sd    <= '0;
        end else begin
            s = m_pipe[SYNC-1];
            for (int c = 0; c < CH; c++) begin
                sel  = edge_sel[2*c +: 2];
                ev   = (sel == 2'b01 && s[c] && !m_sd[c]) ||
                       (sel == 2'b10 && !s[c] && m_sd[c]) ||
                       (sel == 2'b11 && s[c] != m_sd[c]);
                gate = level_gate[c] && ((sel == 2'b01 && !s[c]) || (sel == 2'b10 && s[c]));
                wlen = (longint'(length[c*W +: W]) + 1) * (longint'(scale) + 1);
                n_rem[c]   = m_rem[c];
                n_done[c]  = 1'b0;
                n_abort[c] = 1'b0;
                if (sclr) begin
                    n_rem[c] = 0;
                end else if (sel == 2'b00) begin
                    if (n_rem[c] > 0) n_abort[c] = 1'b1;
                    n_rem[c] = 0;
                end else if (n_rem[c] > 0) begin
                    if (gate) begin
                        n_abort[c] = 1'b1;
                        n_rem[c]   = 0;
                    end else if (ev && retrig[c]) begin
                        n_rem[c] = wlen;
                    end else begin
                        n_rem[c] = n_rem[c] - 1;
                        if (n_rem[c] == 0) n_done[c] = 1'b1;
                    end
                end else if (ev) begin
                    n_rem[c] = wlen;
                end
                n_act[c] = (n_rem[c] > 0);
            end
            m_rem   <= n_rem;
            m_act   <= n_act;
            m_done  <= n_done;
            m_abort <= n_abort;
            m_any   <= sclr ? 1'b0 : |m_act;
            m_sd    <= s;
            m_pipe[0] <= sig;
            for (int k = 1; k < SYNC; k++) m_pipe[k] <= m_pipe[k-1];
        end
    end

    // Per-cycle comparison and pulse/active counters, sampled mid-cycle
    int act_cnt [CH];
    int done_cnt [CH];
    int abort_cnt [CH];

    always @(negedge clk) begin
        chk("active", int'(active), int'(m_act));
        chk("done", int'(done), int'(m_done));
        chk("abort", int'(abort), int'(m_abort));
        chk("any_active", int'(any_active), int'(m_any));
        for (int c = 0; c < CH; c++) begin
            act_cnt[c]   += int'(active[c]);
            done_cnt[c]  += int'(done[c]);
            abort_cnt[c] += int'(abort[c]);
        end
    end

    int b_act, b_done, b_abort;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic mark(input int c);
        b_act   = act_cnt[c];
        b_done  = done_cnt[c];
        b_abort = abort_cnt[c];
    endtask

    task automatic expect_win(input string nm, input int c, input int e_act, input int e_done, input int e_abort);
        chk({nm, "_active_clks"}, act_cnt[c] - b_act, e_act);
        chk({nm, "_done_pulses"}, done_cnt[c] - b_done, e_done);
        chk({nm, "_abort_pulses"}, abort_cnt[c] - b_abort, e_abort);
    endtask

    initial begin
        aclr_n     = 1'b1;
        sclr       = 1'b0;
        sig        = '0;
        scale      = '0;
        length     = '0;
        edge_sel   = '0;
        retrig     = '0;
        level_gate = '0;
        for (int c = 0; c < CH; c++) begin
            act_cnt[c] = 0;
            done_cnt[c] = 0;
            abort_cnt[c] = 0;
        end
        #1 aclr_n = 1'b0;
        #1;
        chk("rst_active", int'(active), 0);
        chk("rst_pulses", int'(done | abort), 0);
        chk("rst_any", int'(any_active), 0);
        #10 aclr_n = 1'b1;
        cyc(3);

        // 1: ch0 rise, scale 3, length 4 -> 20 clk window, latency 3 edges
        scale = 16'd3;
        length[0*W +: W] = 16'd4;
        edge_sel[1:0] = 2'b01;
        cyc(3);
        mark(0);
        sig[0] = 1'b1;
        cyc(2);
        chk("t1_before_latency", int'(active[0]), 0);
        cyc(1);
        chk("t1_after_latency", int'(active[0]), 1);
        cyc(30);
        expect_win("t1", 0, 20, 1, 0);
        sig[0] = 1'b0;
        edge_sel[1:0] = 2'b00;
        cyc(5);

        // 2: ch1 fall with level gate, sig returns high after 5 clk
        sig[1] = 1'b1;
        cyc(5);
        edge_sel[3:2] = 2'b10;
        level_gate[1] = 1'b1;
        scale = 16'd0;
        length[1*W +: W] = 16'd9;
        cyc(2);
        mark(1);
        sig[1] = 1'b0;
        cyc(5);
        sig[1] = 1'b1;
        cyc(20);
        expect_win("t2", 1, 5, 0, 1);
        edge_sel[3:2] = 2'b00;
        level_gate[1] = 1'b0;
        cyc(3);

        // 3: ch2 rise with retrigger 10 clk into a 16 clk window, then without
        edge_sel[5:4] = 2'b01;
        retrig[2] = 1'b1;
        scale = 16'd1;
        length[2*W +: W] = 16'd7;
        cyc(2);
        mark(2);
        sig[2] = 1'b1;
        cyc(5);
        sig[2] = 1'b0;
        cyc(5);
        sig[2] = 1'b1;
        cyc(30);
        expect_win("t3_retrig", 2, 26, 1, 0);
        sig[2] = 1'b0;
        cyc(5);
        retrig[2] = 1'b0;
        mark(2);
        sig[2] = 1'b1;
        cyc(5);
        sig[2] = 1'b0;
        cyc(5);
        sig[2] = 1'b1;
        cyc(30);
        expect_win("t3_noretrig", 2, 16, 1, 0);
        sig[2] = 1'b0;
        edge_sel[5:4] = 2'b00;
        cyc(5);

        // 4: ch3 both edges, minimum window, four toggles
        edge_sel[7:6] = 2'b11;
        scale = 16'd0;
        length[3*W +: W] = 16'd0;
        cyc(2);
        mark(3);
        repeat (4) begin
            sig[3] = ~sig[3];
            cyc(4);
        end
        cyc(5);
        expect_win("t4", 3, 4, 4, 0);

        // 4b: channel switched off mid-window aborts
        length[3*W +: W] = 16'd20;
        cyc(2);
        mark(3);
        sig[3] = 1'b1;
        cyc(5);
        edge_sel[7:6] = 2'b00;
        cyc(5);
        expect_win("t4_seloff", 3, 3, 0, 1);
        sig[3] = 1'b0;
        cyc(3);

        // 5: sclr mid-window with sig held high
        edge_sel[1:0] = 2'b01;
        scale = 16'd3;
        length[0*W +: W] = 16'd4;
        cyc(2);
        mark(0);
        sig[0] = 1'b1;
        cyc(8);
        sclr = 1'b1;
        cyc(1);
        sclr = 1'b0;
        cyc(30);
        expect_win("t5_sclr", 0, 6, 0, 0);
        chk("t5_idle_after", int'(active[0]), 0);
        chk("t5_any_after", int'(any_active), 0);

        // 5b: length changed mid-window does not affect the running window
        sig[0] = 1'b0;
        cyc(3);
        scale = 16'd0;
        length[0*W +: W] = 16'd9;
        cyc(2);
        mark(0);
        sig[0] = 1'b1;
        cyc(5);
        length[0*W +: W] = 16'd2;
        cyc(20);
        expect_win("t5_len_change", 0, 10, 1, 0);

        // 6: async reset with every channel running
        sig = '0;
        edge_sel = 8'b01_01_01_01;
        scale = 16'd0;
        for (int c = 0; c < CH; c++) length[c*W +: W] = 16'd30;
        cyc(3);
        sig = 4'hF;
        cyc(6);
        chk("t6_all_running", int'(active), 15);
        #1 aclr_n = 1'b0;
        #1;
        chk("t6_async_active", int'(active), 0);
        chk("t6_async_pulses", int'(done | abort), 0);
        chk("t6_async_any", int'(any_active), 0);
        #4 aclr_n = 1'b1;
        cyc(1);
        sig = '0;
        cyc(45);
        chk("t6_all_idle_end", int'(active), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
